// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// segment patterns (bit0=a .. bit6=g), scan state type and width helper.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7C;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h67;
    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational BCD to seven-segment decoder, active-high patterns.
// Codes 10..15 decode to all segments off.
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segments
);

    // Map each BCD code to its lit-segment pattern.
    always_comb begin
        segments = SEG_OFF;
        case (bcd)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux.sv
// N-digit multiplexed seven-segment driver with dwell and dead-time blanking.
// Define SEVEN_SEGMENT_MUX_LZB_EN to enable leading-zero blanking.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int SCAN_DIV     = 1,
    parameter int BLANK_CYCLES = 0,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int PRE_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int IDX_W   = clog2_min1(NUM_DIGITS);
    localparam int PRE_W   = clog2_min1(PRE_MAX + 1);
    localparam int BLK_EFF = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] SHOW_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLK_LAST  = PRE_W'(BLK_EFF - 1);

    localparam logic [6:0] SEG_POL =
        ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_POL =
        ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    logic [4*NUM_DIGITS-1:0] snapshot;
    logic [IDX_W-1:0]        idx;
    logic [PRE_W-1:0]        prescaler;
    scan_state_t             state;

    logic [3:0]              cur_bcd;
    logic [6:0]              cur_seg;
    logic [6:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   sel_raw;
    logic [IDX_W-1:0]        idx_next;
    logic                    cur_blank;

    assign cur_bcd  = snapshot[4*int'(idx) +: 4];
    assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    seven_segment_decode u_decode (
        .bcd      (cur_bcd),
        .segments (cur_seg)
    );

`ifdef SEVEN_SEGMENT_MUX_LZB_EN
    logic [NUM_DIGITS-1:0] mask;
    logic [NUM_DIGITS-1:0] mask_in;

    // Blank zero digits from the top down to the first non-zero one.
    always_comb begin
        logic run;
        run     = 1'b1;
        mask_in = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run        = run & (digits_in[4*i +: 4] == 4'd0);
            mask_in[i] = run;
        end
    end

    // Capture the displayed value and its blank mask together.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= '0;
            mask     <= '0;
        end else if (load) begin
            snapshot <= digits_in;
            mask     <= mask_in;
        end
    end

    assign cur_blank = mask[idx];
`else
    // Capture the displayed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= '0;
        end else if (load) begin
            snapshot <= digits_in;
        end
    end

    assign cur_blank = 1'b0;
`endif

    // Active-high view of what the current scan position drives.
    always_comb begin
        seg_raw = SEG_OFF;
        sel_raw = '0;
        if (state == SHOW) begin
            seg_raw = cur_blank ? SEG_OFF : cur_seg;
            sel_raw = NUM_DIGITS'(1) << idx;
        end
    end

    // Scan FSM with registered, polarity-adjusted outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SHOW;
            idx        <= '0;
            prescaler  <= '0;
            segments   <= SEG_POL;
            digit_sel  <= SEL_POL;
            frame_done <= 1'b0;
        end else begin
            segments   <= seg_raw ^ SEG_POL;
            digit_sel  <= sel_raw ^ SEL_POL;
            frame_done <= 1'b0;
            case (state)
                SHOW: begin
                    if (prescaler == SHOW_LAST) begin
                        prescaler  <= '0;
                        frame_done <= (idx == IDX_LAST);
                        if (BLANK_CYCLES > 0) begin
                            state <= BLANK;
                        end else begin
                            idx <= idx_next;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                BLANK: begin
                    if (prescaler == BLK_LAST) begin
                        prescaler <= '0;
                        state     <= SHOW;
                        idx       <= idx_next;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: begin
                    state     <= SHOW;
                    prescaler <= '0;
                end
            endcase
        end
    end

endmodule
